// File: rtl/regfile_sb.sv
// regfile_sb - integer register file with busy scoreboard.
//
// 2**ADDR_W registers of DATA_W bits. Register 0 is hardwired to zero and is
// never busy. Three combinational read ports, fixed LR/SP taps, and two write
// ports: A (ALU results) and B (load data). A per-register busy bit is set by
// issue-stage reservations and cleared by port-B writes.
//
// Ports
//   clock, reset_in       : rising-edge clock, synchronous active-high reset
//   clock_enable          : global advance; low freezes all state
//   mmu_ready             : qualifier for both write ports and reservations
//   regN_addr/data/busy   : read ports 1..3 (data/busy are combinational)
//   regLR_data/regSP_data : stored values of LR_IDX / SP_IDX
//   wa_* / wb_*           : write ports A and B (B wins on address conflict)
//   rsv_en/addr/ready     : destination reservation; ready is combinational
//   busy_count            : number of busy registers
//   wr_collision          : one-cycle pulse after an A/B same-address conflict
module regfile_sb #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 4,
  parameter int LR_IDX = 14,
  parameter int SP_IDX = 15,
  parameter bit BYPASS = 1'b1
) (
  input  logic              clock,
  input  logic              reset_in,
  input  logic              clock_enable,
  input  logic              mmu_ready,
  input  logic [ADDR_W-1:0] reg1_addr,
  input  logic [ADDR_W-1:0] reg2_addr,
  input  logic [ADDR_W-1:0] reg3_addr,
  output logic [DATA_W-1:0] reg1_data,
  output logic [DATA_W-1:0] reg2_data,
  output logic [DATA_W-1:0] reg3_data,
  output logic              reg1_busy,
  output logic              reg2_busy,
  output logic              reg3_busy,
  output logic [DATA_W-1:0] regLR_data,
  output logic [DATA_W-1:0] regSP_data,
  input  logic              wa_en,
  input  logic [ADDR_W-1:0] wa_addr,
  input  logic [DATA_W-1:0] wa_data,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              rsv_ready,
  output logic [ADDR_W:0]   busy_count,
  output logic              wr_collision
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LR_A = ADDR_W'(LR_IDX);
  localparam logic [ADDR_W-1:0] SP_A = ADDR_W'(SP_IDX);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;

  logic wa_eff, wb_eff, collide, rsv_acc, clr_real;

  assign wa_eff  = wa_en && clock_enable && mmu_ready && (wa_addr != '0);
  assign wb_eff  = wb_en && clock_enable && mmu_ready && (wb_addr != '0);
  assign collide = wa_eff && wb_eff && (wa_addr == wb_addr);

  // Ready looks only at the current busy state; a same-cycle B clear of the
  // same register does not make it ready.
  assign rsv_ready = !busy[rsv_addr];
  assign rsv_acc   = rsv_en && rsv_ready && clock_enable && mmu_ready && (rsv_addr != '0);

  // A clear only moves the counter if it actually drops a busy bit and is not
  // overridden by a same-address set. An accepted set is always a 0->1 edge.
  assign clr_real = wb_eff && busy[wb_addr] && !(rsv_acc && (rsv_addr == wb_addr));

  always_ff @(posedge clock) begin
    if (reset_in) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      busy         <= '0;
      busy_count   <= '0;
      wr_collision <= 1'b0;
    end else if (clock_enable) begin
      wr_collision <= collide;
      if (wb_eff)             regs[wb_addr] <= wb_data;
      if (wa_eff && !collide) regs[wa_addr] <= wa_data;
      // Set is applied after clear so a same-address set wins.
      if (wb_eff)  busy[wb_addr]  <= 1'b0;
      if (rsv_acc) busy[rsv_addr] <= 1'b1;
      if (rsv_acc && !clr_real)      busy_count <= busy_count + 1'b1;
      else if (clr_real && !rsv_acc) busy_count <= busy_count - 1'b1;
    end
  end

  logic [ADDR_W-1:0] rd_addr [3];
  logic [DATA_W-1:0] rd_data [3];
  logic              rd_busy [3];

  assign rd_addr[0] = reg1_addr;
  assign rd_addr[1] = reg2_addr;
  assign rd_addr[2] = reg3_addr;

  for (genvar p = 0; p < 3; p++) begin : g_rd
    always_comb begin
      rd_data[p] = regs[rd_addr[p]];
      rd_busy[p] = busy[rd_addr[p]];
      if (BYPASS) begin
        if (wb_eff && (wb_addr == rd_addr[p])) begin
          rd_data[p] = wb_data;
          rd_busy[p] = 1'b0;
        end else if (wa_eff && (wa_addr == rd_addr[p])) begin
          rd_data[p] = wa_data;
        end
      end
    end
  end

  assign reg1_data  = rd_data[0];
  assign reg2_data  = rd_data[1];
  assign reg3_data  = rd_data[2];
  assign reg1_busy  = rd_busy[0];
  assign reg2_busy  = rd_busy[1];
  assign reg3_busy  = rd_busy[2];
  assign regLR_data = regs[LR_A];
  assign regSP_data = regs[SP_A];

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios followed by random
// traffic, all compared against an array-based reference model.
module tb_regfile_sb;
  localparam int DW = 64, AW = 4, N = 16, LR = 14, SP = 15;
  localparam bit BYP = 1'b1;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset_in, clock_enable, mmu_ready;
  logic [AW-1:0] reg1_addr, reg2_addr, reg3_addr;
  logic [DW-1:0] reg1_data, reg2_data, reg3_data, regLR_data, regSP_data;
  logic          reg1_busy, reg2_busy, reg3_busy;
  logic          wa_en, wb_en, rsv_en, rsv_ready, wr_collision;
  logic [AW-1:0] wa_addr, wb_addr, rsv_addr;
  logic [DW-1:0] wa_data, wb_data;
  logic [AW:0]   busy_count;

  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .LR_IDX(LR), .SP_IDX(SP), .BYPASS(BYP)) dut (
    .clock(clock), .reset_in(reset_in), .clock_enable(clock_enable), .mmu_ready(mmu_ready),
    .reg1_addr(reg1_addr), .reg2_addr(reg2_addr), .reg3_addr(reg3_addr),
    .reg1_data(reg1_data), .reg2_data(reg2_data), .reg3_data(reg3_data),
    .reg1_busy(reg1_busy), .reg2_busy(reg2_busy), .reg3_busy(reg3_busy),
    .regLR_data(regLR_data), .regSP_data(regSP_data),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ready(rsv_ready),
    .busy_count(busy_count), .wr_collision(wr_collision)
  );

  int checks = 0, failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model state
  logic [DW-1:0] m_regs [N];
  bit            m_busy [N];
  bit            m_coll;

  function automatic bit eff_a();
    return wa_en && clock_enable && mmu_ready && wa_addr != 0;
  endfunction
  function automatic bit eff_b();
    return wb_en && clock_enable && mmu_ready && wb_addr != 0;
  endfunction
  function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
    if (BYP && eff_b() && wb_addr == a) return wb_data;
    if (BYP && eff_a() && wa_addr == a) return wa_data;
    return m_regs[a];
  endfunction
  function automatic bit exp_busy(input logic [AW-1:0] a);
    return m_busy[a] && !(BYP && eff_b() && wb_addr == a);
  endfunction
  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin m_regs[i] = '0; m_busy[i] = 0; end
    m_coll = 0;
  endtask

  // Apply the edge to the model using the inputs present at that edge.
  task automatic model_edge();
    bit ea, eb, acc;
    if (reset_in) begin model_reset(); return; end
    if (!clock_enable) return;
    ea  = eff_a();
    eb  = eff_b();
    acc = rsv_en && !m_busy[rsv_addr] && mmu_ready && rsv_addr != 0;
    if (ea) m_regs[wa_addr] = wa_data;
    if (eb) m_regs[wb_addr] = wb_data;  // B after A: B wins a same-address conflict
    if (eb) m_busy[wb_addr] = 0;
    if (acc) m_busy[rsv_addr] = 1;
    m_coll = ea && eb && wa_addr == wb_addr;
  endtask

  task automatic check_outputs();
    check("rd1", reg1_data, exp_data(reg1_addr));
    check("rd2", reg2_data, exp_data(reg2_addr));
    check("rd3", reg3_data, exp_data(reg3_addr));
    check("busy1", 64'(reg1_busy), 64'(exp_busy(reg1_addr)));
    check("busy2", 64'(reg2_busy), 64'(exp_busy(reg2_addr)));
    check("busy3", 64'(reg3_busy), 64'(exp_busy(reg3_addr)));
    check("lr", regLR_data, m_regs[LR]);
    check("sp", regSP_data, m_regs[SP]);
    check("rsv_ready", 64'(rsv_ready), 64'(!m_busy[rsv_addr]));
    check("busy_count", 64'(busy_count), 64'(m_count()));
    check("wr_collision", 64'(wr_collision), 64'(m_coll));
  endtask

  task automatic tick();
    #1;
    check_outputs();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic idle();
    reset_in = 0; clock_enable = 1; mmu_ready = 1;
    wa_en = 0; wb_en = 0; rsv_en = 0;
    wa_addr = 0; wb_addr = 0; rsv_addr = 0;
    wa_data = '0; wb_data = '0;
  endtask

  task automatic reserve(input logic [AW-1:0] a);
    idle(); rsv_en = 1; rsv_addr = a; tick();
  endtask

  initial begin
    idle();
    reg1_addr = 0; reg2_addr = 0; reg3_addr = 0;
    reset_in = 1;
    @(posedge clock); #1;
    model_reset();
    idle();

    // Reset state on every address
    for (int a = 0; a < N; a++) begin
      reg1_addr = AW'(a); reg2_addr = AW'(a); reg3_addr = AW'(a); rsv_addr = AW'(a);
      #1;
      check("rst_data", reg1_data, 64'h0);
      check("rst_busy", 64'(reg1_busy), 64'h0);
      check("rst_ready", 64'(rsv_ready), 64'h1);
      tick();
    end
    check("rst_count", 64'(busy_count), 64'h0);

    // r0 ignores writes
    wa_en = 1; wa_addr = 0; wa_data = 64'hDEAD; reg1_addr = 0; tick();
    idle(); #1; check("r0_zero", reg1_data, 64'h0);

    // Dual write, different addresses, with bypass on r5
    wa_en = 1; wa_addr = 3; wa_data = 64'h11;
    wb_en = 1; wb_addr = 5; wb_data = 64'h22; reg2_addr = 5;
    #1; check("byp_r5", reg2_data, 64'h22);
    tick();
    idle(); reg1_addr = 3; reg2_addr = 5; #1;
    check("r3", reg1_data, 64'h11);
    check("r5", reg2_data, 64'h22);
    check("no_coll", 64'(wr_collision), 64'h0);

    // Same-address conflict on r7
    wa_en = 1; wa_addr = 7; wa_data = 64'hAA;
    wb_en = 1; wb_addr = 7; wb_data = 64'hBB; tick();
    idle(); reg1_addr = 7; #1;
    check("r7_b_wins", reg1_data, 64'hBB);
    check("coll_pulse", 64'(wr_collision), 64'h1);
    tick();
    check("coll_one_cycle", 64'(wr_collision), 64'h0);

    // Reserve r4, re-reserve, then clear via B
    reserve(4);
    idle(); reg1_addr = 4; #1;
    check("r4_count", 64'(busy_count), 64'h1);
    check("r4_busy", 64'(reg1_busy), 64'h1);
    rsv_en = 1; rsv_addr = 4; #1;
    check("r4_rerserve_ready", 64'(rsv_ready), 64'h0);
    tick();
    check("r4_count_same", 64'(busy_count), 64'h1);
    idle(); wb_en = 1; wb_addr = 4; wb_data = 64'h5; reg1_addr = 4; #1;
    check("r4_byp_busy", 64'(reg1_busy), 64'h0);
    check("r4_byp_data", reg1_data, 64'h5);
    tick();
    idle(); #1; check("r4_cleared", 64'(busy_count), 64'h0);

    // Clear and reservation of r9 in one cycle, busy and not busy at start
    reserve(9);
    idle(); wb_en = 1; wb_addr = 9; wb_data = 64'h99; rsv_en = 1; rsv_addr = 9; #1;
    check("r9_ready_busy", 64'(rsv_ready), 64'h0);
    tick();
    idle(); reg1_addr = 9; #1; check("r9_not_busy", 64'(reg1_busy), 64'h0);
    wb_en = 1; wb_addr = 9; wb_data = 64'h9A; rsv_en = 1; rsv_addr = 9; tick();
    idle(); reg1_addr = 9; #1;
    check("r9_set_wins", 64'(reg1_busy), 64'h1);
    check("r9_count", 64'(busy_count), 64'h1);

    // mmu_ready low blocks write and reservation
    mmu_ready = 0; wa_en = 1; wa_addr = 2; wa_data = 64'h7; rsv_en = 1; rsv_addr = 2; tick();
    idle(); reg1_addr = 2; #1;
    check("r2_unchanged", reg1_data, 64'h0);
    check("r2_not_busy", 64'(reg1_busy), 64'h0);

    // Reset with busy registers and a concurrent write
    reserve(10); reserve(11);
    idle(); reset_in = 1; wa_en = 1; wa_addr = 6; wa_data = 64'h66; rsv_en = 1; rsv_addr = 12; tick();
    idle(); reg1_addr = 6; reg2_addr = 9; rsv_addr = 12; #1;
    check("rst_mid_count", 64'(busy_count), 64'h0);
    check("rst_mid_data", reg1_data, 64'h0);
    check("rst_mid_busy", 64'(reg2_busy), 64'h0);
    check("rst_mid_ready", 64'(rsv_ready), 64'h1);

    // Random traffic; half the addresses from a small pool to force conflicts
    for (int i = 0; i < 3000; i++) begin
      reset_in     = ($urandom_range(0, 299) == 0);
      clock_enable = ($urandom_range(0, 7) != 0);
      mmu_ready    = ($urandom_range(0, 7) != 0);
      wa_en   = $urandom_range(0, 1) == 1;
      wb_en   = $urandom_range(0, 2) == 0;
      rsv_en  = $urandom_range(0, 1) == 1;
      wa_addr  = $urandom_range(0, 1) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, N-1));
      wb_addr  = $urandom_range(0, 1) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, N-1));
      rsv_addr = $urandom_range(0, 1) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, N-1));
      reg1_addr = $urandom_range(0, 1) ? wb_addr : AW'($urandom_range(0, N-1));
      reg2_addr = $urandom_range(0, 1) ? wa_addr : AW'($urandom_range(0, N-1));
      reg3_addr = AW'($urandom_range(0, N-1));
      wa_data = {$urandom, $urandom};
      wb_data = {$urandom, $urandom};
      tick();
    end

    idle(); tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised successor to the core integer register file: `2**ADDR_W` registers of `DATA_W` bits, three read ports, dedicated LR/SP taps, and two write ports. Port A carries ALU results; port B carries load data. A per-register busy scoreboard is set by issue-stage reservations and cleared by port-B writes. Optional same-cycle write-to-read bypass. Sits between decode/issue and writeback, and is the source of operand-ready stalls.

## Interface
- `DATA_W`, 64, register width
- `ADDR_W`, 4, address width; depth = `2**ADDR_W` (min 2)
- `LR_IDX`, 14, index driven on `regLR_data`
- `SP_IDX`, 15, index driven on `regSP_data`
- `BYPASS`, 1, 1 = same-cycle write data forwarded to read ports; 0 = read returns stored value
- `clock` in 1, single clock, all state on rising edge
- `reset_in` in 1, synchronous, active-high; acts regardless of `clock_enable`
- `clock_enable` in 1, global advance; when low all state holds
- `mmu_ready` in 1, write qualifier for both write ports
- `reg1_addr` / `reg2_addr` / `reg3_addr` in ADDR_W, read addresses
- `reg1_data` / `reg2_data` / `reg3_data` out DATA_W, read data
- `reg1_busy` / `reg2_busy` / `reg3_busy` out 1, operand pending
- `regLR_data`, `regSP_data` out DATA_W, fixed taps (no bypass)
- `wa_en` in 1, `wa_addr` in ADDR_W, `wa_data` in DATA_W: port A
- `wb_en` in 1, `wb_addr` in ADDR_W, `wb_data` in DATA_W: port B
- `rsv_en` in 1, `rsv_addr` in ADDR_W: destination reservation request
- `rsv_ready` out 1, combinational: the reservation would be accepted
- `busy_count` out ADDR_W+1, number of busy registers
- `wr_collision` out 1, registered; one-cycle pulse after a port A/B same-address conflict

## Operation
- Register 0 reads as 0, is never written, and is never busy. Writes and reservations to address 0 are ignored; `rsv_ready`=1 for address 0.
- Effective write: `X_eff = X_en && clock_enable && mmu_ready && X_addr != 0`, for X in {wa, wb}.
- Both ports effective with the same address: port B commits and port A is dropped. `wr_collision`=1 on the next cycle, otherwise 0 (updated only when `clock_enable` is high).
- Different addresses: both ports commit in the same cycle.
- Scoreboard:
  - `rsv_ready = !busy[rsv_addr]`, evaluated on the current busy state. A same-cycle port-B clear does not count.
  - Reservation accepted when `rsv_en && rsv_ready && clock_enable && mmu_ready && rsv_addr != 0`. Acceptance sets `busy[rsv_addr]`.
  - `wb_eff` clears `busy[wb_addr]`.
  - Same address cleared and set in one cycle: set wins, busy stays 1.
  - `wa_eff` never changes busy.
  - `wa_eff` to a busy register still writes data. Ordering is the issue stage's responsibility.
- `busy_count` is updated each enabled cycle by +1 (set only), −1 (clear only) or 0. It never exceeds `2**ADDR_W - 1`.
- Read ports:
  - `BYPASS`=1: data priority is port B eff match, then port A eff match, then stored value. `regN_busy = busy[addr] && !(wb_eff && wb_addr==addr)`.
  - `BYPASS`=0: data = stored value; `regN_busy = busy[addr]`.
- LR/SP taps always show the stored value.

## Timing
- Writes visible in storage on the cycle after the enabled edge. With `BYPASS`=1 they are also visible combinationally in the write cycle.
- Read paths and `rsv_ready` are combinational; zero latency.
- Reset, at the first rising edge with `reset_in`=1:
  - all registers 0, all busy 0, `busy_count`=0, `wr_collision`=0
  - therefore all read data 0, all `regN_busy` 0, `rsv_ready`=1
- Reset wins over simultaneous writes and reservations. Reset mid-operation discards in-flight reservations.
- `clock_enable`=0: no writes, no busy change, no counter change, `wr_collision` holds. Read paths remain live; bypass is inactive because `X_eff`=0.
- `mmu_ready`=0: writes and reservations are blocked. `wr_collision` updates to 0 because neither port is effective.

## Test plan
- Reset, then read all addresses: data 0, busy 0, `busy_count`=0, `rsv_ready`=1. Then write 0xDEAD to r0 via A: r0 still reads 0.
- A writes r3=0x11 and B writes r5=0x22 in the same cycle: next cycle r3=0x11, r5=0x22, `wr_collision`=0. With `BYPASS`=1, reading r5 in the write cycle returns 0x22.
- A writes r7=0xAA and B writes r7=0xBB in the same cycle: r7=0xBB, `wr_collision`=1 for exactly one cycle.
- Reserve r4: `busy_count`=1 and `reg1_busy`=1 for r4. Re-reserve r4: `rsv_ready`=0, no change. B writes r4=0x5: busy clears and `busy_count`=0. In the B-write cycle, with `BYPASS`=1, `reg1_busy`=0 and data=0x5.
- Same cycle: B writes r9 (busy) and a reservation of r9 is presented: `rsv_ready`=0, so the reservation is rejected and r9 ends not busy. Repeat with r9 not busy at the start: ends busy, `busy_count` +1.
- `mmu_ready`=0 with A write r2=0x7 and a reservation of r2: r2 unchanged, not busy. Assert `reset_in` with 3 busy registers and a concurrent write: next cycle everything is 0.
